weight_rd_arbiter: RTL
======================

# weight_rd_arbiter

Round-robin arbiter that shares the single encoder weight-memory read port between NUM_REQ requesters: layer-norm gamma/beta loader, attention, FFN and embedding fetch. It accepts one read per cycle, forwards it to the memory port and tags it with the requester ID. It returns read data to the correct requester, in order, using an ID FIFO that bounds the number of outstanding reads. It sits between the encoder sub-blocks and the memory interface they currently drive directly.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- BUS_WIDTH, 512, memory read data width
- MAX_OUTSTANDING, 8, ID FIFO depth; maximum reads in flight (power of 2, ≥2)
- clk  in  1  clock; the only clock
- rst_n  in  1  reset, synchronous, active-low
- req_rd_en  in  NUM_REQ  per-requester read request; held with address until granted
- req_rd_addr  in  NUM_REQ×32  per-requester byte address
- req_rd_ready  out  NUM_REQ  grant pulse; one-hot or zero; combinational
- req_rd_valid  out  NUM_REQ  per-requester return strobe; one-hot or zero; registered
- req_rd_data  out  BUS_WIDTH  return data, shared by all requesters; qualified by req_rd_valid
- mem_rd_en  out  1  memory read strobe, registered
- mem_rd_addr  out  32  memory read address, registered
- mem_rd_data  in  BUS_WIDTH  memory return data
- mem_rd_valid  in  1  memory return strobe; returns are in issue order, latency ≥1
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current number of reads in flight
- err_unexpected  out  1  sticky flag: mem_rd_valid arrived with no read outstanding

## Operation
- Arbitration:
  - eligible = req_rd_en & {NUM_REQ{outstanding < MAX_OUTSTANDING}}.
  - Round-robin: the search starts at last_grant+1 and wraps modulo NUM_REQ.
  - last_grant resets to NUM_REQ-1, so requester 0 has first priority after reset.
  - At most one grant per cycle. last_grant updates only on a grant.
- Issue:
  - On grant i, register mem_rd_en=1 and mem_rd_addr=req_rd_addr[i].
  - Push i into the ID FIFO.
  - With no grant, mem_rd_en=0 and mem_rd_addr holds its value.
- Return:
  - On mem_rd_valid, pop the FIFO head h.
  - Next cycle: req_rd_valid[h]=1 and req_rd_data=mem_rd_data.
  - req_rd_data holds its value when no return occurs.
- Counter:
  - outstanding = +1 on push, -1 on pop, unchanged when both occur in the same cycle.
- Full FIFO:
  - The full check uses the current-cycle count only. A pop in the same cycle does not free a slot until the next cycle.
- Empty FIFO:
  - mem_rd_valid with outstanding==0 is dropped: no req_rd_valid, no pointer change.
  - err_unexpected is set and stays set until reset.
- Requester contract: a requester must not drop req_rd_en or change its address before req_rd_ready. Behaviour under that violation is unspecified.
- Reset:
  - Takes effect on any cycle, including with reads in flight.
  - Clears the FIFO, its pointers, outstanding, last_grant and err_unexpected.
  - Returns arriving after reset count as unexpected.

## Timing
- Reset values: req_rd_valid=0, req_rd_data=0, mem_rd_en=0, mem_rd_addr=0, outstanding=0, err_unexpected=0. req_rd_ready is 0 while rst_n=0.
- Grant latency: req_rd_en[i] high in cycle N and selected gives req_rd_ready[i]=1 in N and mem_rd_en=1 in N+1.
- Throughput: one issue per cycle, sustained while outstanding < MAX_OUTSTANDING.
- Return latency: mem_rd_valid in cycle M gives req_rd_valid in M+1, i.e. one register stage.
- Pipeline: no bubbles between back-to-back grants to different or the same requester.
- A requester still requesting after its grant competes again in the next cycle.

## Test plan
- Single requester: req 2 reads 0x100. Required: ready[2] in the same cycle; mem_rd_en/addr=0x100 next cycle. Memory returns 0xAB after 3 cycles. Required: valid[2]=1 and data=0xAB one cycle later; outstanding goes 0→1→0.
- Fairness: all 4 requesters hold req_rd_en continuously for 8 cycles. Required grant order: 0,1,2,3,0,1,2,3, one per cycle.
- Backpressure: memory holds off returns; 3 requesters request. Required: exactly MAX_OUTSTANDING=8 grants, then ready stays 0 and outstanding=8.
- Release after backpressure (continues the previous scenario): one return arrives in cycle M. Required: no grant in cycle M, a grant in M+1, and return IDs routed in issue order.
- Simultaneous push/pop: a grant and a mem_rd_valid in the same cycle with outstanding=3. Required: outstanding stays 3; data goes to the oldest requester.
- Error and reset: mem_rd_valid with nothing outstanding. Required: err_unexpected=1, no req_rd_valid. Then assert rst_n=0 for one cycle with 5 reads in flight. Required: all outputs and counters at reset values, and the next grant goes to requester 0.

Source files
------------

// File: rtl/weight_rd_arbiter_if.sv
// Weight-memory read bundle: requester-side request/return lanes plus the shared memory port.
// master is the arbiter side, slave is the environment (requesters and memory).
interface weight_rd_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BUS_WIDTH = 512
);
  logic [NUM_REQ-1:0]        req_rd_en;
  logic [NUM_REQ-1:0][31:0]  req_rd_addr;
  logic [NUM_REQ-1:0]        req_rd_ready;
  logic [NUM_REQ-1:0]        req_rd_valid;
  logic [BUS_WIDTH-1:0]      req_rd_data;
  logic                      mem_rd_en;
  logic [31:0]               mem_rd_addr;
  logic [BUS_WIDTH-1:0]      mem_rd_data;
  logic                      mem_rd_valid;

  modport master (
    input  req_rd_en, req_rd_addr, mem_rd_data, mem_rd_valid,
    output req_rd_ready, req_rd_valid, req_rd_data, mem_rd_en, mem_rd_addr
  );

  modport slave (
    output req_rd_en, req_rd_addr, mem_rd_data, mem_rd_valid,
    input  req_rd_ready, req_rd_valid, req_rd_data, mem_rd_en, mem_rd_addr
  );
endinterface

// File: rtl/weight_rd_arbiter.sv
// Round-robin arbiter sharing one weight-memory read port among NUM_REQ requesters.
// Issued requester IDs are queued so in-order memory returns reach the right requester.
module weight_rd_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned BUS_WIDTH       = 512,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  weight_rd_arbiter_if.master                rd,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_unexpected
);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = PW + 1;

  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      cand;
  logic               gnt_any;
  logic               full;
  logic               pop;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      id_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  // Full uses this cycle's count only; a same-cycle pop frees its slot next cycle.
  assign full     = (outstanding >= CW'(MAX_OUTSTANDING));
  assign eligible = rst_n ? (rd.req_rd_en & {NUM_REQ{!full}}) : '0;
  assign pop      = rd.mem_rd_valid && (outstanding != '0);

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = last_grant;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((32'(last_grant) + k) % NUM_REQ);
      if (!gnt_any && eligible[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    grant = '0;
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  assign rd.req_rd_ready = grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant        <= IW'(NUM_REQ - 1);
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      outstanding       <= '0;
      err_unexpected    <= 1'b0;
      rd.mem_rd_en      <= 1'b0;
      rd.mem_rd_addr    <= '0;
      rd.req_rd_valid   <= '0;
      rd.req_rd_data    <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) id_fifo[i] <= '0;
    end else begin
      rd.mem_rd_en    <= gnt_any;
      rd.req_rd_valid <= '0;
      if (gnt_any) begin
        last_grant       <= gnt_idx;
        rd.mem_rd_addr   <= rd.req_rd_addr[gnt_idx];
        id_fifo[wr_ptr]  <= gnt_idx;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd.req_rd_valid[id_fifo[rd_ptr]] <= 1'b1;
        rd.req_rd_data                   <= rd.mem_rd_data;
        rd_ptr                           <= rd_ptr + 1'b1;
      end
      // A return with nothing in flight is dropped and flagged until reset.
      if (rd.mem_rd_valid && (outstanding == '0)) err_unexpected <= 1'b1;
      if (gnt_any && !pop)      outstanding <= outstanding + 1'b1;
      else if (pop && !gnt_any) outstanding <= outstanding - 1'b1;
    end
  end
endmodule
